// File: rtl/pipeline_stall_chain_if.sv
// Handshake bundle for pipeline_stall_chain.
// The master side is the surrounding system: producer, resource and consumer.
// The slave side is the stall chain itself.
interface pipeline_stall_chain_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OCC_W  = 3
);
    // Producer -> chain (pre segment input)
    logic [DATA_W-1:0] in_data_from_producer;
    logic              in_valid_from_producer;
    logic              in_flush_from_producer;
    logic              out_stall_to_producer;

    // Chain -> resource (pre segment output)
    logic [DATA_W-1:0] out_data_to_resource;
    logic              out_valid_to_resource;
    logic              out_flush_to_resource;
    logic              in_stall_from_resource;

    // Resource -> chain (post segment input)
    logic [DATA_W-1:0] in_data_from_resource;
    logic              in_valid_from_resource;
    logic              in_flush_from_resource;
    logic              out_stall_to_resource;

    // Chain -> consumer (post segment output)
    logic [DATA_W-1:0] out_data_to_consumer;
    logic              out_valid_to_consumer;
    logic              out_flush_to_consumer;
    logic              in_stall_from_consumer;

    // Stall profiling
    logic [OCC_W-1:0]  out_occupancy;

    modport master (
        output in_data_from_producer,
        output in_valid_from_producer,
        output in_flush_from_producer,
        input  out_stall_to_producer,
        input  out_data_to_resource,
        input  out_valid_to_resource,
        input  out_flush_to_resource,
        output in_stall_from_resource,
        output in_data_from_resource,
        output in_valid_from_resource,
        output in_flush_from_resource,
        input  out_stall_to_resource,
        input  out_data_to_consumer,
        input  out_valid_to_consumer,
        input  out_flush_to_consumer,
        output in_stall_from_consumer,
        input  out_occupancy
    );

    modport slave (
        input  in_data_from_producer,
        input  in_valid_from_producer,
        input  in_flush_from_producer,
        output out_stall_to_producer,
        output out_data_to_resource,
        output out_valid_to_resource,
        output out_flush_to_resource,
        input  in_stall_from_resource,
        input  in_data_from_resource,
        input  in_valid_from_resource,
        input  in_flush_from_resource,
        output out_stall_to_resource,
        output out_data_to_consumer,
        output out_valid_to_consumer,
        output out_flush_to_consumer,
        input  in_stall_from_consumer,
        output out_occupancy
    );
endinterface

// File: rtl/pipeline_stall_chain.sv
// Parametrised elastic stall chain.
// Pre segment: PRE_STAGES skid-buffered stages from producer to resource.
// Post segment: POST_STAGES skid-buffered stages from resource to consumer.
// Each stage has a main register and a skid register; the stall a stage
// presents upstream is its skid valid, so no stall path is combinational
// across the chain and each stage sustains one word per cycle.
module pipeline_stall_chain #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PRE_STAGES  = 3,
    parameter int unsigned POST_STAGES = 1,
    parameter int unsigned OCC_W       = $clog2(2 * PRE_STAGES + 1)
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_stall_chain_if.slave  bus
);

    // ------------------------------------------------------------------
    // Pre segment state
    // ------------------------------------------------------------------
    logic [PRE_STAGES-1:0] r_pre_mv;
    logic [PRE_STAGES-1:0] r_pre_sv;
    logic [DATA_W-1:0]     r_pre_md [PRE_STAGES];
    logic [DATA_W-1:0]     r_pre_sd [PRE_STAGES];

    logic [PRE_STAGES-1:0] w_pre_mv_nxt;
    logic [PRE_STAGES-1:0] w_pre_sv_nxt;
    logic [DATA_W-1:0]     w_pre_md_nxt [PRE_STAGES];
    logic [DATA_W-1:0]     w_pre_sd_nxt [PRE_STAGES];

    logic [PRE_STAGES-1:0] w_pre_up_valid;
    logic [DATA_W-1:0]     w_pre_up_data [PRE_STAGES];
    logic [PRE_STAGES-1:0] w_pre_dn_stall;
    logic [PRE_STAGES-1:0] w_pre_acc;
    logic [PRE_STAGES-1:0] w_pre_take;

    // ------------------------------------------------------------------
    // Post segment state
    // ------------------------------------------------------------------
    logic [POST_STAGES-1:0] r_post_mv;
    logic [POST_STAGES-1:0] r_post_sv;
    logic [DATA_W-1:0]      r_post_md [POST_STAGES];
    logic [DATA_W-1:0]      r_post_sd [POST_STAGES];

    logic [POST_STAGES-1:0] w_post_mv_nxt;
    logic [POST_STAGES-1:0] w_post_sv_nxt;
    logic [DATA_W-1:0]      w_post_md_nxt [POST_STAGES];
    logic [DATA_W-1:0]      w_post_sd_nxt [POST_STAGES];

    logic [POST_STAGES-1:0] w_post_up_valid;
    logic [DATA_W-1:0]      w_post_up_data [POST_STAGES];
    logic [POST_STAGES-1:0] w_post_dn_stall;
    logic [POST_STAGES-1:0] w_post_acc;
    logic [POST_STAGES-1:0] w_post_take;

    // ------------------------------------------------------------------
    // Flush pulses and occupancy
    // ------------------------------------------------------------------
    logic             r_flush_res;
    logic             r_flush_con;
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_nxt;
    int unsigned      w_occ_sum;

    // ------------------------------------------------------------------
    // Stage linkage: each stage's upstream is the previous stage's main
    // register, and its downstream stall is the next stage's skid valid.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < PRE_STAGES; g++) begin : g_pre_link
        if (g == 0) begin : g_head
            assign w_pre_up_valid[g] = bus.in_valid_from_producer;
            assign w_pre_up_data[g]  = bus.in_data_from_producer;
        end else begin : g_body
            assign w_pre_up_valid[g] = r_pre_mv[g-1];
            assign w_pre_up_data[g]  = r_pre_md[g-1];
        end
        if (g == PRE_STAGES - 1) begin : g_tail
            assign w_pre_dn_stall[g] = bus.in_stall_from_resource;
        end else begin : g_inner
            assign w_pre_dn_stall[g] = r_pre_sv[g+1];
        end
    end

    for (genvar g = 0; g < POST_STAGES; g++) begin : g_post_link
        if (g == 0) begin : g_head
            assign w_post_up_valid[g] = bus.in_valid_from_resource;
            assign w_post_up_data[g]  = bus.in_data_from_resource;
        end else begin : g_body
            assign w_post_up_valid[g] = r_post_mv[g-1];
            assign w_post_up_data[g]  = r_post_md[g-1];
        end
        if (g == POST_STAGES - 1) begin : g_tail
            assign w_post_dn_stall[g] = bus.in_stall_from_consumer;
        end else begin : g_inner
            assign w_post_dn_stall[g] = r_post_sv[g+1];
        end
    end

    assign w_pre_acc   = w_pre_up_valid & ~r_pre_sv;
    assign w_pre_take  = r_pre_mv & ~w_pre_dn_stall;
    assign w_post_acc  = w_post_up_valid & ~r_post_sv;
    assign w_post_take = r_post_mv & ~w_post_dn_stall;

    // Pre segment next state; flush overrides any accept or move.
    always_comb begin
        w_pre_mv_nxt = r_pre_mv;
        w_pre_sv_nxt = r_pre_sv;
        for (int i = 0; i < PRE_STAGES; i++) begin
            w_pre_md_nxt[i] = r_pre_md[i];
            w_pre_sd_nxt[i] = r_pre_sd[i];
            if (!r_pre_mv[i] || w_pre_take[i]) begin
                // Main is free this edge: skid refills it first to keep order.
                if (r_pre_sv[i]) begin
                    w_pre_mv_nxt[i] = 1'b1;
                    w_pre_md_nxt[i] = r_pre_sd[i];
                end else if (w_pre_acc[i]) begin
                    w_pre_mv_nxt[i] = 1'b1;
                    w_pre_md_nxt[i] = w_pre_up_data[i];
                end else begin
                    w_pre_mv_nxt[i] = 1'b0;
                end
                w_pre_sv_nxt[i] = 1'b0;
            end else if (w_pre_acc[i]) begin
                // Main is held: the word already in flight lands in the skid.
                w_pre_sv_nxt[i] = 1'b1;
                w_pre_sd_nxt[i] = w_pre_up_data[i];
            end
        end
        if (bus.in_flush_from_producer) begin
            w_pre_mv_nxt = '0;
            w_pre_sv_nxt = '0;
        end
    end

    // Post segment next state; same stage rule as the pre segment.
    always_comb begin
        w_post_mv_nxt = r_post_mv;
        w_post_sv_nxt = r_post_sv;
        for (int i = 0; i < POST_STAGES; i++) begin
            w_post_md_nxt[i] = r_post_md[i];
            w_post_sd_nxt[i] = r_post_sd[i];
            if (!r_post_mv[i] || w_post_take[i]) begin
                if (r_post_sv[i]) begin
                    w_post_mv_nxt[i] = 1'b1;
                    w_post_md_nxt[i] = r_post_sd[i];
                end else if (w_post_acc[i]) begin
                    w_post_mv_nxt[i] = 1'b1;
                    w_post_md_nxt[i] = w_post_up_data[i];
                end else begin
                    w_post_mv_nxt[i] = 1'b0;
                end
                w_post_sv_nxt[i] = 1'b0;
            end else if (w_post_acc[i]) begin
                w_post_sv_nxt[i] = 1'b1;
                w_post_sd_nxt[i] = w_post_up_data[i];
            end
        end
        if (bus.in_flush_from_resource) begin
            w_post_mv_nxt = '0;
            w_post_sv_nxt = '0;
        end
    end

    // Occupancy is taken from the next state so the register matches the
    // stage contents it is stored alongside (and reads 0 after a flush).
    always_comb begin
        w_occ_sum = 0;
        for (int i = 0; i < PRE_STAGES; i++) begin
            w_occ_sum = w_occ_sum + 32'(w_pre_mv_nxt[i]) + 32'(w_pre_sv_nxt[i]);
        end
        w_occ_nxt = OCC_W'(w_occ_sum);
    end

    // Pre segment registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre_mv <= '0;
            r_pre_sv <= '0;
            for (int i = 0; i < PRE_STAGES; i++) begin
                r_pre_md[i] <= '0;
                r_pre_sd[i] <= '0;
            end
        end else begin
            r_pre_mv <= w_pre_mv_nxt;
            r_pre_sv <= w_pre_sv_nxt;
            for (int i = 0; i < PRE_STAGES; i++) begin
                r_pre_md[i] <= w_pre_md_nxt[i];
                r_pre_sd[i] <= w_pre_sd_nxt[i];
            end
        end
    end

    // Post segment registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_post_mv <= '0;
            r_post_sv <= '0;
            for (int i = 0; i < POST_STAGES; i++) begin
                r_post_md[i] <= '0;
                r_post_sd[i] <= '0;
            end
        end else begin
            r_post_mv <= w_post_mv_nxt;
            r_post_sv <= w_post_sv_nxt;
            for (int i = 0; i < POST_STAGES; i++) begin
                r_post_md[i] <= w_post_md_nxt[i];
                r_post_sd[i] <= w_post_sd_nxt[i];
            end
        end
    end

    // Flush pulses follow the flush request by one cycle; occupancy register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flush_res <= 1'b0;
            r_flush_con <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_flush_res <= bus.in_flush_from_producer;
            r_flush_con <= bus.in_flush_from_resource;
            r_occ       <= w_occ_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken straight from registers.
    // ------------------------------------------------------------------
    assign bus.out_stall_to_producer = r_pre_sv[0];
    assign bus.out_data_to_resource  = r_pre_md[PRE_STAGES-1];
    assign bus.out_valid_to_resource = r_pre_mv[PRE_STAGES-1];
    assign bus.out_flush_to_resource = r_flush_res;

    assign bus.out_stall_to_resource = r_post_sv[0];
    assign bus.out_data_to_consumer  = r_post_md[POST_STAGES-1];
    assign bus.out_valid_to_consumer = r_post_mv[POST_STAGES-1];
    assign bus.out_flush_to_consumer = r_flush_con;

    assign bus.out_occupancy = r_occ;

endmodule

// File: tb/tb_pipeline_stall_chain.sv
// Scoreboard bench for pipeline_stall_chain (PRE=3, POST=1).
// Producer words are queued as expected at acceptance; negedge monitors pop
// and compare whenever a word is taken at the resource or the consumer.
module tb_pipeline_stall_chain;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PRE    = 3;
    localparam int unsigned POST   = 1;
    localparam int unsigned OCC_W  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_chain_if #(.DATA_W(DATA_W), .OCC_W(OCC_W)) bus ();

    pipeline_stall_chain #(
        .DATA_W      (DATA_W),
        .PRE_STAGES  (PRE),
        .POST_STAGES (POST),
        .OCC_W       (OCC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Resource model: in loop mode it forwards pre output into the post input.
    logic        res_loop  = 1'b0;
    logic        res_stall = 1'b0;
    logic        con_stall = 1'b0;
    logic        rv_drv    = 1'b0;
    logic [31:0] rd_drv    = '0;

    assign bus.in_stall_from_resource = res_loop ? (res_stall | bus.out_stall_to_resource)
                                                 : res_stall;
    assign bus.in_valid_from_resource = res_loop ? (bus.out_valid_to_resource &
                                                    ~bus.in_stall_from_resource) : rv_drv;
    assign bus.in_data_from_resource  = res_loop ? bus.out_data_to_resource : rd_drv;
    assign bus.in_stall_from_consumer = con_stall;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_res[$];
    logic [31:0] q_con[$];
    int          res_cnt = 0;
    int          con_cnt = 0;
    int          prod_stall_cnt = 0;
    int          sent_cnt = 0;
    bit          send_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare every word actually handed over.
    always @(negedge clk) begin
        if (reset && bus.out_valid_to_resource && !bus.in_stall_from_resource) begin
            res_cnt++;
            if (q_res.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL res_unexpected: got 0x%0h expected none", bus.out_data_to_resource);
            end else begin
                check("res_data", bus.out_data_to_resource, q_res.pop_front());
            end
        end
        if (reset && bus.out_valid_to_consumer && !bus.in_stall_from_consumer) begin
            con_cnt++;
            if (q_con.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL con_unexpected: got 0x%0h expected none", bus.out_data_to_consumer);
            end else begin
                check("con_data", bus.out_data_to_consumer, q_con.pop_front());
            end
        end
        if (reset && bus.out_stall_to_producer) prod_stall_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present n consecutive words; a word counts as accepted at the edge after
    // a negedge that shows no producer stall.
    task automatic send(input logic [31:0] base, input int n, input bit push_res,
                        input bit push_con);
        int waited;
        bit acc;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            acc    = 1'b0;
            bus.in_valid_from_producer = 1'b1;
            bus.in_data_from_producer  = base + 32'(k);
            while (!acc) begin
                @(negedge clk);
                if (!bus.out_stall_to_producer) begin
                    acc = 1'b1;
                    sent_cnt++;
                    if (push_res) q_res.push_back(base + 32'(k));
                    if (push_con) q_con.push_back(base + 32'(k));
                end
                step();
                if (!acc) begin
                    waited++;
                    if (waited > 200) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL send_timeout: word 0x%0h never accepted", base + 32'(k));
                        bus.in_valid_from_producer = 1'b0;
                        return;
                    end
                end
            end
        end
        bus.in_valid_from_producer = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && (q_res.size() != 0 || q_con.size() != 0); i++) begin
            @(negedge clk);
        end
        check("drain_empty", 32'(q_res.size() + q_con.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_res"}, 32'(bus.out_valid_to_resource), 32'd0);
        check({tag, "_stall_prod"}, 32'(bus.out_stall_to_producer), 32'd0);
        check({tag, "_flush_res"}, 32'(bus.out_flush_to_resource), 32'd0);
        check({tag, "_valid_con"}, 32'(bus.out_valid_to_consumer), 32'd0);
        check({tag, "_stall_res"}, 32'(bus.out_stall_to_resource), 32'd0);
        check({tag, "_flush_con"}, 32'(bus.out_flush_to_consumer), 32'd0);
        check({tag, "_occ"}, 32'(bus.out_occupancy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int c0;
        int first;
        int last;
        int cnt;

        bus.in_valid_from_producer = 1'b0;
        bus.in_data_from_producer  = '0;
        bus.in_flush_from_producer = 1'b0;
        bus.in_flush_from_resource = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        reset = 1'b1;
        step();

        // 1: free-flowing stream, latency 3 and one word per cycle
        res_loop = 1'b1;
        prod_stall_cnt = 0;
        r0 = res_cnt;
        c0 = con_cnt;
        send_done = 1'b0;
        fork
            begin
                send(32'h1, 16, 1'b1, 1'b1);
                send_done = 1'b1;
            end
        join_none
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("latency", 32'(bus.out_valid_to_resource), (k == 4) ? 32'd1 : 32'd0);
        end
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid_to_consumer) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
        end
        check("stream_count", 32'(cnt), 32'd16);
        check("stream_contig", 32'(last - first + 1), 32'd16);
        check("stream_res_cnt", 32'(res_cnt - r0), 32'd16);
        check("stream_con_cnt", 32'(con_cnt - c0), 32'd16);
        check("no_prod_stall", 32'(prod_stall_cnt), 32'd0);
        wait_idle(50);

        // 2: permanent resource stall fills exactly 6, then drains in order
        step();
        res_stall = 1'b1;
        sent_cnt  = 0;
        send_done = 1'b0;
        r0 = res_cnt;
        fork
            begin
                send(32'h101, 8, 1'b1, 1'b1);
                send_done = 1'b1;
            end
        join_none
        repeat (12) step();
        @(negedge clk);
        check("full_occ", 32'(bus.out_occupancy), 32'd6);
        check("full_stall_prod", 32'(bus.out_stall_to_producer), 32'd1);
        check("full_accepted", 32'(sent_cnt), 32'd6);
        step();
        res_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("drain_rate", 32'(bus.out_valid_to_resource), 32'd1);
        end
        for (int i = 0; i < 100 && !send_done; i++) step();
        wait_idle(100);
        check("drain_res_cnt", 32'(res_cnt - r0), 32'd8);

        // 3: alternating resource stall with a continuous producer
        step();
        r0 = res_cnt;
        c0 = con_cnt;
        send_done = 1'b0;
        fork
            begin
                send(32'h1000, 32, 1'b1, 1'b1);
                send_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 2000 && !send_done; i++) begin
            step();
            res_stall = ~res_stall;
        end
        res_stall = 1'b0;
        wait_idle(200);
        check("alt_res_cnt", 32'(res_cnt - r0), 32'd32);
        check("alt_con_cnt", 32'(con_cnt - c0), 32'd32);

        // 4: pre segment flush drops held words and the word presented with it
        step();
        res_stall = 1'b1;
        step();
        send(32'hF1, 4, 1'b0, 1'b0);
        @(negedge clk);
        check("preflush_occ", 32'(bus.out_occupancy), 32'd4);
        step();
        bus.in_valid_from_producer = 1'b1;
        bus.in_data_from_producer  = 32'hFF;
        bus.in_flush_from_producer = 1'b1;
        step();
        bus.in_valid_from_producer = 1'b0;
        bus.in_flush_from_producer = 1'b0;
        @(negedge clk);
        check("flush_occ", 32'(bus.out_occupancy), 32'd0);
        check("flush_pulse", 32'(bus.out_flush_to_resource), 32'd1);
        check("flush_valid_res", 32'(bus.out_valid_to_resource), 32'd0);
        check("flush_stall_prod", 32'(bus.out_stall_to_producer), 32'd0);
        step();
        @(negedge clk);
        check("flush_pulse_end", 32'(bus.out_flush_to_resource), 32'd0);
        step();
        res_stall = 1'b0;
        send(32'h201, 2, 1'b1, 1'b1);
        wait_idle(50);

        // 5: consumer stall fills the post stage; post flush leaves pre alone
        step();
        res_loop  = 1'b0;
        res_stall = 1'b1;
        con_stall = 1'b1;
        send(32'h401, 2, 1'b1, 1'b1);
        repeat (4) step();
        rv_drv = 1'b1;
        rd_drv = 32'h301;
        @(negedge clk);
        check("post_stall_0", 32'(bus.out_stall_to_resource), 32'd0);
        step();
        rd_drv = 32'h302;
        @(negedge clk);
        check("post_stall_1", 32'(bus.out_stall_to_resource), 32'd0);
        step();
        rv_drv = 1'b0;
        @(negedge clk);
        check("post_stall_2", 32'(bus.out_stall_to_resource), 32'd1);
        check("post_valid_con", 32'(bus.out_valid_to_consumer), 32'd1);
        check("post_pre_occ", 32'(bus.out_occupancy), 32'd2);
        step();
        rv_drv = 1'b1;
        rd_drv = 32'h3FF;
        bus.in_flush_from_resource = 1'b1;
        step();
        rv_drv = 1'b0;
        bus.in_flush_from_resource = 1'b0;
        @(negedge clk);
        check("pflush_pulse", 32'(bus.out_flush_to_consumer), 32'd1);
        check("pflush_stall_res", 32'(bus.out_stall_to_resource), 32'd0);
        check("pflush_valid_con", 32'(bus.out_valid_to_consumer), 32'd0);
        check("pflush_flush_res", 32'(bus.out_flush_to_resource), 32'd0);
        check("pflush_pre_occ", 32'(bus.out_occupancy), 32'd2);
        step();
        @(negedge clk);
        check("pflush_pulse_end", 32'(bus.out_flush_to_consumer), 32'd0);
        step();
        con_stall = 1'b0;
        res_stall = 1'b0;
        res_loop  = 1'b1;
        wait_idle(100);

        // 6: reset with every stage full, then a clean restart
        step();
        con_stall = 1'b1;
        send(32'h501, 2, 1'b1, 1'b0);
        repeat (8) step();
        res_stall = 1'b1;
        send(32'h511, 6, 1'b0, 1'b0);
        repeat (2) step();
        @(negedge clk);
        check("full2_occ", 32'(bus.out_occupancy), 32'd6);
        check("full2_stall_prod", 32'(bus.out_stall_to_producer), 32'd1);
        check("full2_stall_res", 32'(bus.out_stall_to_resource), 32'd1);
        check("full2_valid_con", 32'(bus.out_valid_to_consumer), 32'd1);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check_all_zero("midreset");
        step();
        reset     = 1'b1;
        res_stall = 1'b0;
        con_stall = 1'b0;
        step();
        c0 = con_cnt;
        send(32'h601, 4, 1'b1, 1'b1);
        wait_idle(100);
        repeat (10) step();
        check("restart_con_cnt", 32'(con_cnt - c0), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_chain.md
Name: pipeline_stall_chain

Overview:
Parametrised successor of the fixed four-stage stall pipeline. It carries a word from producer to shared resource through PRE_STAGES elastic stages, and from resource to consumer through POST_STAGES elastic stages. Every stage has a skid buffer, so each stall output is registered (no combinational stall path across the chain) and every stage sustains one word per cycle. Per-segment flush, and an occupancy count that stall-profiling logic reads.

Parameters:
DATA_W, 32, data width of all data ports
PRE_STAGES, 3, stages between producer and resource (>=1)
POST_STAGES, 1, stages between resource and consumer (>=1)
OCC_W, $clog2(2*PRE_STAGES+1), width of out_occupancy

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-low; sampled on clk edge
in_data_from_producer  in  DATA_W  producer word
in_valid_from_producer  in  1  producer word valid
in_flush_from_producer  in  1  flush pre segment
out_stall_to_producer  out  1  producer must hold word
out_data_to_resource  out  DATA_W  word to resource
out_valid_to_resource  out  1  word valid to resource
out_flush_to_resource  out  1  one-cycle flush pulse to resource
in_stall_from_resource  in  1  resource cannot accept
in_data_from_resource  in  DATA_W  resource result
in_valid_from_resource  in  1  result valid
in_flush_from_resource  in  1  flush post segment
out_stall_to_resource  out  1  resource must hold result
out_data_to_consumer  out  DATA_W  word to consumer
out_valid_to_consumer  out  1  word valid to consumer
out_flush_to_consumer  out  1  one-cycle flush pulse to consumer
in_stall_from_consumer  in  1  consumer cannot accept
out_occupancy  out  OCC_W  valid entries in pre segment, 0..2*PRE_STAGES

Behaviour:
- Reset (reset==0 at edge): all main/skid valids cleared, data regs 0, all stall/valid/flush outputs 0, occupancy 0. Reset mid-stream discards all in-flight words. No word is accepted in the reset cycle.
- Stage state: main reg (mv, md) and skid reg (sv, sd). out_valid=mv, out_data=md, out_stall=sv (registered).
- Upstream accept: in_valid && !sv. Downstream take: mv && !in_stall.
- Stage update per edge:
  - If !mv or take: main <= skid if sv, else accepted input; if neither, mv<=0. sv<=0.
  - Else (main held): accepted input -> skid.
- Word order is preserved. No word is dropped or duplicated except by flush or reset.
- Latency: with no stalls, a word accepted at edge N is valid at out_valid_to_resource after edge N+PRE_STAGES-1, i.e. PRE_STAGES cycles from presentation. Post segment: POST_STAGES cycles.
- Capacity: each segment holds exactly 2×stages words. Under a permanent downstream stall, the pre segment accepts exactly 2*PRE_STAGES words, then out_stall_to_producer=1 with no overflow.
- Stall release: when a downstream stall drops, the drain is one word per cycle. Each upstream stall deasserts one cycle after its stage's skid empties.
- Flush (pre segment): in_flush_from_producer==1 at edge clears mv/sv of all pre stages. A producer word presented in the same cycle is dropped (flush dominates accept). out_flush_to_resource=1 for exactly the next cycle. Continuous flush gives a continuous pulse.
- Flush (post segment): identical, using in_flush_from_resource, post stages and out_flush_to_consumer. The segments flush independently.
- Reset dominates flush.
- out_occupancy: registered sum of mv+sv over pre stages, updated every edge. It reads 0 the cycle after a flush.
- out_stall_to_resource = sv of first post stage.

Test Plan:
- Stream 0x1..0x10, no stalls, PRE=3/POST=1 -> first word on out_valid_to_resource 3 cycles after presentation. Loop resource to consumer: data in order, 1 word/cycle, out_stall_to_producer never 1.
- in_stall_from_resource held 1 while producer streams -> exactly 6 words accepted, out_stall_to_producer=1, out_occupancy=6. Release stall -> words drain in order, one per cycle, nothing lost.
- Alternating resource stall (1 on, 1 off) with continuous producer -> all 32 words delivered in order, no duplicates.
- Fill 4 words, assert in_flush_from_producer for 1 cycle with a new valid word -> occupancy 0 next cycle, out_flush_to_resource high exactly 1 cycle, the flushed words and the new word never appear.
- in_stall_from_consumer=1 with resource streaming (POST=1) -> out_stall_to_resource=1 after 2 words. in_flush_from_resource then clears the post stage, pulses out_flush_to_consumer for 1 cycle, and the pre segment is unaffected.
- Assert reset=0 mid-stream with all stages full -> next cycle every valid/stall/flush output is 0 and occupancy 0; streaming restarts cleanly after release.
